// File: rtl/ex_stage.sv
// Execute stage of the 5-stage RV32I pipeline: operand forwarding, ALU,
// branch/jump resolution and the EX/MEM pipeline register.
module ex_stage #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stallM,
   input  logic            flushM,
   input  logic [XLEN-1:0] pcE,
   input  logic [XLEN-1:0] pcPlus4E,
   input  logic [XLEN-1:0] rd1E,
   input  logic [XLEN-1:0] rd2E,
   input  logic [XLEN-1:0] immExtE,
   input  logic [4:0]      rdE,
   input  logic            regWriteE,
   input  logic            memReadE,
   input  logic            memWriteE,
   input  logic            aluSrcE,
   input  logic            branchE,
   input  logic            jumpE,
   input  logic            jalrE,
   input  logic [1:0]      resultSrcE,
   input  logic [3:0]      aluControlE,
   input  logic [2:0]      addressingmodeE,
   input  logic [1:0]      forwardAE,
   input  logic [1:0]      forwardBE,
   input  logic [XLEN-1:0] resultW,
   output logic            pcSrcE,
   output logic [XLEN-1:0] pcTargetE,
   output logic [XLEN-1:0] aluResultM,
   output logic [XLEN-1:0] writeDataM,
   output logic [XLEN-1:0] pcPlus4M,
   output logic [4:0]      rdM,
   output logic            regWriteM,
   output logic            memReadM,
   output logic            memWriteM,
   output logic [1:0]      resultSrcM,
   output logic [2:0]      addressingmodeM
);

   logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b, alu_result;
   logic [4:0]      shamt;
   logic            br_eq, br_lt, br_ltu, br_taken;

   logic [XLEN-1:0] alu_result_q, alu_result_d;
   logic [XLEN-1:0] write_data_q, write_data_d;
   logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
   logic [4:0]      rd_q, rd_d;
   logic            reg_write_q, reg_write_d;
   logic            mem_read_q, mem_read_d;
   logic            mem_write_q, mem_write_d;
   logic [1:0]      result_src_q, result_src_d;
   logic [2:0]      addr_mode_q, addr_mode_d;

   // Forwarding muxes; the reserved select 11 falls back to register-file data.
   always_comb begin
      unique case (forwardAE)
         2'b01:   fwd_a = resultW;
         2'b10:   fwd_a = alu_result_q;
         default: fwd_a = rd1E;
      endcase
      unique case (forwardBE)
         2'b01:   fwd_b = resultW;
         2'b10:   fwd_b = alu_result_q;
         default: fwd_b = rd2E;
      endcase
   end

   assign src_a = fwd_a;
   assign src_b = aluSrcE ? immExtE : fwd_b;
   assign shamt = src_b[4:0];

   // ALU; undefined operation codes yield zero.
   always_comb begin
      alu_result = '0;
      unique case (aluControlE)
         4'b0000: alu_result = src_a + src_b;
         4'b0001: alu_result = src_a - src_b;
         4'b0010: alu_result = src_a & src_b;
         4'b0011: alu_result = src_a | src_b;
         4'b0100: alu_result = src_a ^ src_b;
         4'b0101: alu_result = src_a << shamt;
         4'b0110: alu_result = src_a >> shamt;
         4'b0111: alu_result = $unsigned($signed(src_a) >>> shamt);
         4'b1000: alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
         4'b1001: alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
         4'b1010: alu_result = src_b;
         default: alu_result = '0;
      endcase
   end

   // Branch compare uses the forwarded register operands, never the immediate.
   assign br_eq  = (fwd_a == fwd_b);
   assign br_lt  = ($signed(fwd_a) < $signed(fwd_b));
   assign br_ltu = (fwd_a < fwd_b);

   // Branch condition decode keyed by funct3.
   always_comb begin
      br_taken = 1'b0;
      unique case (addressingmodeE)
         3'b000:  br_taken = br_eq;
         3'b001:  br_taken = ~br_eq;
         3'b100:  br_taken = br_lt;
         3'b101:  br_taken = ~br_lt;
         3'b110:  br_taken = br_ltu;
         3'b111:  br_taken = ~br_ltu;
         default: br_taken = 1'b0;
      endcase
   end

   assign pcSrcE    = jumpE | (branchE & br_taken);
   assign pcTargetE = jalrE ? ((fwd_a + immExtE) & ~{{(XLEN-1){1'b0}}, 1'b1})
                            : (pcE + immExtE);

   // EX/MEM next state: flush beats stall, stall holds, otherwise capture.
   always_comb begin
      alu_result_d = alu_result_q;
      write_data_d = write_data_q;
      pc_plus4_d   = pc_plus4_q;
      rd_d         = rd_q;
      reg_write_d  = reg_write_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      result_src_d = result_src_q;
      addr_mode_d  = addr_mode_q;
      if (flushM) begin
         alu_result_d = '0;
         write_data_d = '0;
         pc_plus4_d   = '0;
         rd_d         = '0;
         reg_write_d  = 1'b0;
         mem_read_d   = 1'b0;
         mem_write_d  = 1'b0;
         result_src_d = '0;
         addr_mode_d  = '0;
      end else if (!stallM) begin
         alu_result_d = alu_result;
         write_data_d = fwd_b;
         pc_plus4_d   = pcPlus4E;
         rd_d         = rdE;
         reg_write_d  = regWriteE;
         mem_read_d   = memReadE;
         mem_write_d  = memWriteE;
         result_src_d = resultSrcE;
         addr_mode_d  = addressingmodeE;
      end
   end

   // EX/MEM register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_result_q <= '0;
         write_data_q <= '0;
         pc_plus4_q   <= '0;
         rd_q         <= '0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         result_src_q <= '0;
         addr_mode_q  <= '0;
      end else begin
         alu_result_q <= alu_result_d;
         write_data_q <= write_data_d;
         pc_plus4_q   <= pc_plus4_d;
         rd_q         <= rd_d;
         reg_write_q  <= reg_write_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         result_src_q <= result_src_d;
         addr_mode_q  <= addr_mode_d;
      end
   end

   assign aluResultM      = alu_result_q;
   assign writeDataM      = write_data_q;
   assign pcPlus4M        = pc_plus4_q;
   assign rdM             = rd_q;
   assign regWriteM       = reg_write_q;
   assign memReadM        = mem_read_q;
   assign memWriteM       = mem_write_q;
   assign resultSrcM      = result_src_q;
   assign addressingmodeM = addr_mode_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
module tb_ex_stage;

   logic        clk, rst_n, stallM, flushM;
   logic [31:0] pcE, pcPlus4E, rd1E, rd2E, immExtE, resultW;
   logic [4:0]  rdE;
   logic        regWriteE, memReadE, memWriteE, aluSrcE, branchE, jumpE, jalrE;
   logic [1:0]  resultSrcE, forwardAE, forwardBE;
   logic [3:0]  aluControlE;
   logic [2:0]  addressingmodeE;
   logic        pcSrcE;
   logic [31:0] pcTargetE, aluResultM, writeDataM, pcPlus4M;
   logic [4:0]  rdM;
   logic        regWriteM, memReadM, memWriteM;
   logic [1:0]  resultSrcM;
   logic [2:0]  addressingmodeM;

   int n_checks = 0;
   int n_errors = 0;

   ex_stage #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .stallM(stallM), .flushM(flushM),
      .pcE(pcE), .pcPlus4E(pcPlus4E), .rd1E(rd1E), .rd2E(rd2E), .immExtE(immExtE),
      .rdE(rdE), .regWriteE(regWriteE), .memReadE(memReadE), .memWriteE(memWriteE),
      .aluSrcE(aluSrcE), .branchE(branchE), .jumpE(jumpE), .jalrE(jalrE),
      .resultSrcE(resultSrcE), .aluControlE(aluControlE),
      .addressingmodeE(addressingmodeE), .forwardAE(forwardAE), .forwardBE(forwardBE),
      .resultW(resultW), .pcSrcE(pcSrcE), .pcTargetE(pcTargetE),
      .aluResultM(aluResultM), .writeDataM(writeDataM), .pcPlus4M(pcPlus4M),
      .rdM(rdM), .regWriteM(regWriteM), .memReadM(memReadM), .memWriteM(memWriteM),
      .resultSrcM(resultSrcM), .addressingmodeM(addressingmodeM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic clr_inputs();
      stallM = 0; flushM = 0;
      pcE = 0; pcPlus4E = 0; rd1E = 0; rd2E = 0; immExtE = 0; resultW = 0;
      rdE = 0; regWriteE = 0; memReadE = 0; memWriteE = 0; aluSrcE = 0;
      branchE = 0; jumpE = 0; jalrE = 0; resultSrcE = 0; aluControlE = 0;
      addressingmodeE = 0; forwardAE = 0; forwardBE = 0;
   endtask

   // Advance one rising edge and settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic alu_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input logic [31:0] exp);
      clr_inputs();
      aluControlE = op; rd1E = a; rd2E = b;
      tick();
      check(tag, aluResultM, exp);
   endtask

   initial begin
      clr_inputs();
      rst_n = 0;
      #12;
      check("rst_alu", aluResultM, 0);
      check("rst_rd", {27'd0, rdM}, 0);
      check("rst_ctl", {27'd0, regWriteM, memReadM, memWriteM, resultSrcM}, 0);
      rst_n = 1;

      // First capture after reset.
      clr_inputs();
      rd1E = 5; rd2E = 7; rdE = 3; regWriteE = 1; pcPlus4E = 32'h44;
      resultSrcE = 2'b01; addressingmodeE = 3'b010; memReadE = 1;
      tick();
      check("add_res", aluResultM, 12);
      check("add_rd", {27'd0, rdM}, 3);
      check("add_rw", {31'd0, regWriteM}, 1);
      check("add_pc4", pcPlus4M, 32'h44);
      check("add_ctl", {26'd0, memReadM, resultSrcM, addressingmodeM}, {26'd0, 1'b1, 2'b01, 3'b010});

      // Asynchronous reset between edges.
      #2 rst_n = 0;
      #1;
      check("arst_alu", aluResultM, 0);
      check("arst_rd", {27'd0, rdM}, 0);
      check("arst_rw", {31'd0, regWriteM}, 0);
      @(negedge clk);
      rst_n = 1;
      #1;
      check("post_rst_hold", aluResultM, 0);

      // ALU sweep.
      alu_op(4'b0001, 3, 5, "sub", 32'hFFFF_FFFE);
      alu_op(4'b0111, 32'h8000_0000, 31, "sra", 32'hFFFF_FFFF);
      alu_op(4'b0110, 32'h8000_0000, 31, "srl", 32'h0000_0001);
      alu_op(4'b1000, 32'hFFFF_FFFF, 1, "slt", 1);
      alu_op(4'b1001, 32'hFFFF_FFFF, 1, "sltu", 0);
      alu_op(4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, "and", 32'h00F0_1200);
      alu_op(4'b0011, 32'hF000_0001, 32'h0F00_0010, "or", 32'hFF00_0011);
      alu_op(4'b0100, 32'hFFFF_0000, 32'h0F0F_0F0F, "xor", 32'hF0F0_0F0F);
      alu_op(4'b0101, 32'h0000_0003, 32'h0000_0024, "sll_shamt5", 32'h0000_0030);
      alu_op(4'b1111, 32'h1234_5678, 32'h1, "undef_op", 0);
      clr_inputs();
      aluControlE = 4'b1010; aluSrcE = 1; immExtE = 32'h1234_5000; rd2E = 32'hDEAD;
      tick();
      check("passb", aluResultM, 32'h1234_5000);

      // Forwarding.
      clr_inputs();
      rd1E = 32'h10;
      tick();
      check("fwd_setup", aluResultM, 32'h10);
      clr_inputs();
      forwardAE = 2'b10; immExtE = 4; aluSrcE = 1;
      tick();
      check("fwd_a_mem", aluResultM, 32'h14);
      clr_inputs();
      forwardBE = 2'b01; resultW = 32'hAB; rd2E = 32'h55; memWriteE = 1;
      aluSrcE = 1; immExtE = 8;
      tick();
      check("fwd_b_wb", writeDataM, 32'hAB);
      check("fwd_b_imm_alu", aluResultM, 8);
      check("fwd_b_mw", {31'd0, memWriteM}, 1);
      clr_inputs();
      forwardAE = 2'b11; forwardBE = 2'b11; rd1E = 7; rd2E = 1; resultW = 32'h900;
      tick();
      check("fwd_rsvd", aluResultM, 8);

      // Branch / jump, combinational.
      clr_inputs();
      addressingmodeE = 3'b100; rd1E = 32'hFFFF_FFFF; rd2E = 1; branchE = 1;
      pcE = 32'h100; immExtE = 32'h20; aluSrcE = 1;
      #1;
      check("blt_src", {31'd0, pcSrcE}, 1);
      check("blt_tgt", pcTargetE, 32'h120);
      addressingmodeE = 3'b110;
      #1;
      check("bltu_src", {31'd0, pcSrcE}, 0);
      addressingmodeE = 3'b111;
      #1;
      check("bgeu_src", {31'd0, pcSrcE}, 1);
      addressingmodeE = 3'b101;
      #1;
      check("bge_src", {31'd0, pcSrcE}, 0);
      rd2E = 32'hFFFF_FFFF; addressingmodeE = 3'b000;
      #1;
      check("beq_src", {31'd0, pcSrcE}, 1);
      addressingmodeE = 3'b001;
      #1;
      check("bne_src", {31'd0, pcSrcE}, 0);
      addressingmodeE = 3'b010;
      rd2E = 1;
      #1;
      check("b010_src", {31'd0, pcSrcE}, 0);
      addressingmodeE = 3'b000; rd2E = 32'hFFFF_FFFF; branchE = 0;
      #1;
      check("nobr_src", {31'd0, pcSrcE}, 0);
      clr_inputs();
      jumpE = 1; jalrE = 1; rd1E = 32'h203; immExtE = 0; pcE = 32'h400;
      #1;
      check("jalr_src", {31'd0, pcSrcE}, 1);
      check("jalr_tgt", pcTargetE, 32'h202);

      // Stall and flush.
      clr_inputs();
      rd1E = 1; rd2E = 2; rdE = 5; regWriteE = 1; memWriteE = 1;
      tick();
      check("pre_stall", aluResultM, 3);
      stallM = 1; rd1E = 100; rdE = 9; regWriteE = 0;
      tick();
      check("stall1_alu", aluResultM, 3);
      check("stall1_rd", {27'd0, rdM}, 5);
      rd1E = 200; rdE = 11; memWriteE = 0;
      tick();
      check("stall2_alu", aluResultM, 3);
      check("stall2_ctl", {30'd0, regWriteM, memWriteM}, 3);
      flushM = 1;
      tick();
      check("flush_ctl", {30'd0, regWriteM, memWriteM}, 0);
      check("flush_rd", {27'd0, rdM}, 0);
      check("flush_alu", aluResultM, 0);

      // x0 destination is latched unchanged.
      clr_inputs();
      rdE = 0; regWriteE = 1; rd1E = 32'h77;
      tick();
      check("x0_rw", {31'd0, regWriteM}, 1);
      check("x0_alu", aluResultM, 32'h77);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage RV32I pipeline. It consumes the ID/EX register outputs, applies operand forwarding, and evaluates the ALU. It resolves branches and jumps and computes the redirect target. Results are latched into an internal EX/MEM pipeline register that feeds the memory stage.

Parameters:
XLEN, 32, datapath width (only 32 supported)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stallM  in  1  hold EX/MEM register contents
flushM  in  1  bubble EX/MEM register (zero controls)
pcE  in  32  PC of instruction in EX
pcPlus4E  in  32  PC+4 of instruction in EX
rd1E, rd2E  in  32  register-file read data
immExtE  in  32  sign-extended immediate
rdE  in  5  destination register
regWriteE, memReadE, memWriteE, aluSrcE, branchE, jumpE, jalrE  in  1 each  control
resultSrcE  in  2  writeback select
aluControlE  in  4  ALU operation
addressingmodeE  in  3  funct3 (branch condition / load-store width)
forwardAE, forwardBE  in  2  forwarding select from hazard unit
resultW  in  32  writeback-stage result
pcSrcE  out  1  redirect fetch (combinational)
pcTargetE  out  32  redirect address (combinational)
aluResultM  out  32  registered ALU result
writeDataM  out  32  registered forwarded rs2 (store data)
pcPlus4M  out  32  registered PC+4
rdM  out  5  registered destination
regWriteM, memReadM, memWriteM  out  1 each  registered control
resultSrcM  out  2  registered control
addressingmodeM  out  3  registered funct3

Behaviour:
- Forwarding mux A/B:
  - 00 selects rd1E/rd2E.
  - 01 selects resultW.
  - 10 selects aluResultM (own register output).
  - 11 is reserved; treat as 00.
- srcA = fwdA.
- srcB = aluSrcE ? immExtE : fwdB.
- writeData = fwdB (never the immediate).
- aluControlE encodings:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SRA
  - 1000 SLT (signed), 1001 SLTU
  - 1010 PASSB (LUI)
  - others produce 0.
- Shift amount is srcB[4:0]. All arithmetic is modulo 2^32, with no overflow flag.
- Branch condition uses fwdA vs fwdB (not srcB), keyed by addressingmodeE:
  - 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - 010 and 011 are never taken.
- pcSrcE = jumpE | (branchE & taken). This is combinational, with zero cycles latency.
- pcTargetE = jalrE ? ((fwdA + immExtE) & ~1) : (pcE + immExtE). Computed regardless of pcSrcE.
- EX/MEM register (single stage, latency 1 cycle):
  - rst_n low (async, immediate): all outputs become 0.
  - Otherwise on posedge, flushM=1: controls (regWriteM, memReadM, memWriteM, resultSrcM, addressingmodeM) become 0, and data fields become 0.
  - Else stallM=1: all outputs hold.
  - Else: capture aluResult, writeData, pcPlus4E, rdE and controls.
- flushM has priority over stallM.
- rdE == 0 with regWriteE=1 is latched as-is; x0 suppression belongs to the register file.
- Reset asserted mid-operation discards the in-flight instruction. After rst_n rises, outputs stay 0 until the first capturing edge.
- pcSrcE/pcTargetE depend only on current inputs and aluResultM, and are unaffected by stallM/flushM.

Test Plan:
- Reset: rst_n=0 asynchronously between edges -> all M outputs 0 immediately. Release, apply ADD rd1E=5, rd2E=7, rdE=3, regWriteE=1 -> next edge aluResultM=12, rdM=3, regWriteM=1.
- ALU sweep: SUB 3-5 -> 0xFFFFFFFE. SRA 0x80000000 by 31 -> 0xFFFFFFFF. SRL same -> 1. SLT 0xFFFFFFFF,1 -> 1. SLTU same -> 0. PASSB imm 0x12345000 with aluSrcE=1 -> 0x12345000.
- Forwarding: aluResultM=0x10, forwardAE=10, rd1E=0, immExtE=4, aluSrcE=1, ADD -> aluResultM=0x14. forwardBE=01, resultW=0xAB, memWriteE=1 -> writeDataM=0xAB.
- Branch/jump:
  - BLT (100) fwdA=0xFFFFFFFF, fwdB=1, branchE=1, pcE=0x100, imm=0x20 -> pcSrcE=1, pcTargetE=0x120.
  - BLTU same operands -> pcSrcE=0.
  - JALR fwdA=0x203, imm=0 -> pcSrcE=1, pcTargetE=0x202.
- Stall/flush: stallM=1 for 2 cycles with changing inputs -> M outputs unchanged. flushM=1 and stallM=1 together -> regWriteM=memWriteM=0, rdM=0.
